burst_mem_responder: RTL and testbench
======================================

# burst_mem_responder

Synthesizable physical-memory responder for the 64-bit burst interface that the cacheline adaptor drives on the CPU's `pmem_*` port. It accepts one line-sized (256-bit) read or write request at a time and answers after a fixed, parameterized latency with a 4-beat burst. Storage is an on-chip word array. It replaces the behavioural memory model in FPGA builds and serves as the bench-side memory in integration tests.

## Interface
Parameters:
- `LINE_IDX_W`, default 8: line-index bits; capacity is 2^LINE_IDX_W lines × 32 B (default 8 KiB).
- `LATENCY`, default 4: cycles from request accept to first `pmem_resp`. Legal range is 2..15.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pmem_read`  in  1  line read request.
- `pmem_write`  in  1  line write request.
- `pmem_address`  in  32  byte address; bits [4:0] are ignored, bits [LINE_IDX_W+4:5] select the line, upper bits are ignored (aliasing).
- `pmem_wdata`  in  64  write beat, sampled in every `pmem_resp` cycle of a write burst.
- `pmem_rdata`  out  64  read beat; valid when `pmem_resp`=1 during a read burst, otherwise 0.
- `pmem_resp`  out  1  beat strobe; high for exactly 4 consecutive cycles per request.
- `proto_err`  out  1  sticky flag; set when `pmem_read` and `pmem_write` are high together in IDLE. Cleared only by `rst`.

## Operation
- FSM states: IDLE, WAIT, BURST.
- IDLE: if `pmem_read` or `pmem_write` is high:
  - latch the operation and the line index;
  - load the latency counter with LATENCY−1;
  - go to WAIT.
- Simultaneous read and write in IDLE: read wins, the write is dropped, and `proto_err` is set.
- WAIT: the counter decrements each cycle. When it reaches 0, go to BURST with beat counter = 0.
  - For reads, the array read for beat 0 is issued on the last WAIT cycle.
- BURST: `pmem_resp`=1 in every BURST cycle. The beat counter (2 bits) increments each cycle. After beat 3, return to IDLE.
- Beat order: beat k carries line bits [64k+63:64k], ascending (k = 0..3). There is no critical-word-first ordering.
- Read: `pmem_rdata` = word {line, k} in beat k.
- Write: word {line, k} ← `pmem_wdata` at the end of beat k. The write takes effect for any read accepted afterwards.
- Request inputs are ignored outside IDLE. Address and operation are latched at accept, so changes mid-request have no effect.
- Requester contract: the requester deasserts the request in the cycle after the last `pmem_resp`. If the request is still high in IDLE, it is accepted as a new request.
- Reset:
  - FSM → IDLE; `pmem_resp`=0, `pmem_rdata`=0, `proto_err`=0, counters=0.
  - Array contents are not reset and are undefined at power-up.
  - Reset mid-burst aborts the burst. Beats already written stay written.

## Timing
- Request accepted in cycle T (IDLE, request high).
- `pmem_resp` is high in cycles T+LATENCY through T+LATENCY+3, then low in T+LATENCY+4 (IDLE).
- Earliest next accept is T+LATENCY+4, so minimum request spacing is LATENCY+4 cycles.
- Array: single-port synchronous RAM with 1-cycle read latency.
  - Read address for beat k+1 is presented in beat k's cycle.
  - `pmem_rdata` is registered directly from the RAM output and muxed to 0 when not in a read BURST.
- Read-during-write never occurs, because a request is either read or write.
- `proto_err` rises in cycle T+1.

## Structure
- Shared package `burst_mem_pkg`:
  - `BURST_LEN`=4, `BEAT_W`=64, `LINE_OFF_W`=5;
  - typedef `bmr_state_e` {IDLE, WAIT, BURST};
  - typedef `bmr_op_e` {OP_RD, OP_WR}.
- Sub-module `burst_mem_array`:
  - single-port sync RAM, depth 2^(LINE_IDX_W+2) × 64;
  - ports: `clk`, `we`, `addr`, `wdata`, `rdata`.
- The top holds the FSM, counters, address latch and output muxing.

## Test plan
- Write then read, LATENCY=4: write line 0x100 with beats 0x11…11, 0x22…22, 0x33…33, 0x44…44; accept at T → resp at T+4..T+7. Read 0x100 → same four beats in order, resp at T'+4..T'+7, `pmem_rdata`=0 outside.
- Offset and alias: read 0x11F returns line 0x100's data. With LINE_IDX_W=8, read 0x2100 also returns line 0x100's data.
- Read+write together in IDLE → read burst only, `proto_err`=1 from T+1, and the target line is unchanged by the dropped write.
- Request held high after the last beat → second burst starts exactly LATENCY+4 cycles after the first accept. Address toggled during WAIT → data comes from the latched line.
- `rst` asserted during beat 2 of a write → resp=0 next cycle. Re-read shows beats 0–1 new and beats 2–3 old.
- LATENCY=2 build: back-to-back reads of 16 lines match a scoreboard, with resp pulse width always 4.

Source files
------------

// File: rtl/burst_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : burst_mem_pkg
// Description : Shared constants and types for the burst memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package burst_mem_pkg;

    localparam int BURST_LEN  = 4;
    localparam int BEAT_W     = 64;
    localparam int LINE_OFF_W = 5;
    localparam int BEAT_IDX_W = $clog2(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } bmr_state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } bmr_op_e;

endpackage
`default_nettype wire

// File: rtl/burst_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : burst_mem_array
// Description : Single-port synchronous word RAM with 1-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_mem_array
    import burst_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BEAT_W-1:0] wdata,
    output logic [BEAT_W-1:0] rdata
);

    logic [BEAT_W-1:0] r_mem [0:(2**ADDR_W)-1];

    // Contents are deliberately left unreset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end else begin
            rdata <= r_mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : burst_mem_responder
// Description : Line-sized read/write responder answering with 4-beat bursts
//               after a fixed latency, backed by an on-chip word array.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int LINE_IDX_W = 8,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [BEAT_W-1:0] pmem_wdata,
    output logic [BEAT_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              proto_err
);

    localparam int c_ram_aw = LINE_IDX_W + BEAT_IDX_W;

    bmr_state_e             r_state, w_state_nxt;
    bmr_op_e                r_op, w_op_nxt;
    logic [LINE_IDX_W-1:0]  r_line, w_line_nxt;
    logic [3:0]             r_lat_cnt, w_lat_nxt;
    logic [BEAT_IDX_W-1:0]  r_beat, w_beat_nxt;
    logic                   r_proto_err, w_err_set;

    logic                   w_ram_we;
    logic [BEAT_IDX_W-1:0]  w_ram_beat;
    logic [c_ram_aw-1:0]    w_ram_addr;
    logic [BEAT_W-1:0]      w_ram_rdata;
    logic                   w_addr_unused;

    // Offset bits and aliased upper bits do not take part in line selection.
    assign w_addr_unused = ^{pmem_address[31:LINE_IDX_W+LINE_OFF_W],
                             pmem_address[LINE_OFF_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= OP_RD;
            r_line      <= '0;
            r_lat_cnt   <= '0;
            r_beat      <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_line      <= w_line_nxt;
            r_lat_cnt   <= w_lat_nxt;
            r_beat      <= w_beat_nxt;
            r_proto_err <= r_proto_err | w_err_set;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_line_nxt  = r_line;
        w_lat_nxt   = r_lat_cnt;
        w_beat_nxt  = r_beat;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    w_state_nxt = WAIT;
                    // Read wins a simultaneous request; the write is dropped.
                    w_op_nxt    = pmem_read ? OP_RD : OP_WR;
                    w_line_nxt  = pmem_address[LINE_IDX_W+LINE_OFF_W-1:LINE_OFF_W];
                    w_lat_nxt   = 4'(LATENCY - 1);
                    w_err_set   = pmem_read && pmem_write;
                end
            end
            WAIT: begin
                w_lat_nxt = r_lat_cnt - 4'd1;
                if (r_lat_cnt <= 4'd1) begin
                    w_state_nxt = BURST;
                    w_beat_nxt  = '0;
                end
            end
            BURST: begin
                w_beat_nxt = r_beat + 2'd1;
                if (r_beat == 2'(BURST_LEN - 1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Reads prefetch one beat ahead to cover the RAM's read latency; beat 0
    // is fetched during the last WAIT cycle.
    assign w_ram_we   = (r_state == BURST) && (r_op == OP_WR) && !rst;
    assign w_ram_beat = (r_state != BURST) ? '0 :
                        (r_op == OP_WR)    ? r_beat : (r_beat + 2'd1);
    assign w_ram_addr = {r_line, w_ram_beat};

    burst_mem_array #(
        .ADDR_W (c_ram_aw)
    ) u_array (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (pmem_wdata),
        .rdata (w_ram_rdata)
    );

    assign pmem_resp  = (r_state == BURST);
    assign pmem_rdata = ((r_state == BURST) && (r_op == OP_RD)) ? w_ram_rdata : '0;
    assign proto_err  = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_mem_responder
// Description : Directed self-checking bench for burst_mem_responder
//               (LATENCY=4 and LATENCY=2 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [63:0] wdata [2];
    logic [63:0] rdata [2];
    logic        resp  [2];
    logic        perr  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    burst_mem_responder #(.LINE_IDX_W(8), .LATENCY(4)) dut_l4 (
        .clk(clk), .rst(rst),
        .pmem_read(rd[0]), .pmem_write(wr[0]), .pmem_address(addr[0]),
        .pmem_wdata(wdata[0]), .pmem_rdata(rdata[0]), .pmem_resp(resp[0]),
        .proto_err(perr[0])
    );

    burst_mem_responder #(.LINE_IDX_W(8), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst),
        .pmem_read(rd[1]), .pmem_write(wr[1]), .pmem_address(addr[1]),
        .pmem_wdata(wdata[1]), .pmem_rdata(rdata[1]), .pmem_resp(resp[1]),
        .proto_err(perr[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input int i);
        logic [255:0] v;
        for (int k = 0; k < 4; k++) begin
            v[64*k +: 64] = {16'hB00C, 8'(i), 8'(k), 32'h5A5A_0000 + 32'(i * 16 + k)};
        end
        return v;
    endfunction

    // Called at a negedge; the request is accepted at the next posedge (cycle T).
    // Returns at the negedge of cycle T+LAT+4, leaving the request up if keep.
    task automatic req(input string tag, input int s, input bit r, input bit w,
                       input logic [31:0] a, input logic [255:0] line,
                       input bit keep, input bit toggle);
        int lat;
        bit in_burst;
        lat = (s == 0) ? 4 : 2;
        rd[s]    = r;
        wr[s]    = w;
        addr[s]  = a;
        wdata[s] = '0;
        for (int j = 1; j <= lat + 4; j++) begin
            @(negedge clk);
            in_burst = (j >= lat) && (j <= lat + 3);
            check({tag, "_resp"}, {63'b0, resp[s]}, {63'b0, in_burst});
            if (in_burst && r) begin
                check({tag, "_rdata"}, rdata[s], line[64*(j-lat) +: 64]);
            end else begin
                check({tag, "_rdata_zero"}, rdata[s], 64'h0);
            end
            if (in_burst && w) begin
                wdata[s] = r ? ~line[64*(j-lat) +: 64] : line[64*(j-lat) +: 64];
            end
            if (r && w && j == 1) begin
                check({tag, "_perr_t1"}, {63'b0, perr[s]}, 64'h1);
            end
            if (toggle && j == 1) begin
                addr[s] = a ^ 32'h0000_0020;
            end
        end
        if (!keep) begin
            rd[s] = 1'b0;
            wr[s] = 1'b0;
        end
    endtask

    logic [255:0] l1, l2, lr;
    logic [255:0] sb [16];

    initial begin
        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        l2 = {64'hDDDD_0003_0000_0200, 64'hCCCC_0002_0000_0200,
              64'hBBBB_0001_0000_0200, 64'hAAAA_0000_0000_0200};
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset_resp",  {63'b0, resp[s]}, 64'h0);
            check("reset_rdata", rdata[s], 64'h0);
            check("reset_perr",  {63'b0, perr[s]}, 64'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Basic write/read, offset and alias on the LATENCY=4 instance
        req("wr_100",   0, 1'b0, 1'b1, 32'h0000_0100, l1, 1'b0, 1'b0);
        req("rd_100",   0, 1'b1, 1'b0, 32'h0000_0100, l1, 1'b0, 1'b0);
        req("rd_11f",   0, 1'b1, 1'b0, 32'h0000_011F, l1, 1'b0, 1'b0);
        req("rd_2100",  0, 1'b1, 1'b0, 32'h0000_2100, l1, 1'b0, 1'b0);

        // Held request rolls straight into the next accept; address toggle in WAIT
        req("wr_200",   0, 1'b0, 1'b1, 32'h0000_0200, l2, 1'b0, 1'b0);
        req("hold_1",   0, 1'b1, 1'b0, 32'h0000_0100, l1, 1'b1, 1'b0);
        req("hold_2",   0, 1'b1, 1'b0, 32'h0000_0200, l2, 1'b0, 1'b0);
        req("toggle",   0, 1'b1, 1'b0, 32'h0000_0100, l1, 1'b0, 1'b1);

        // Simultaneous read and write
        check("perr_pre", {63'b0, perr[0]}, 64'h0);
        req("rdwr",     0, 1'b1, 1'b1, 32'h0000_0100, l1, 1'b0, 1'b0);
        check("perr_sticky", {63'b0, perr[0]}, 64'h1);
        req("rd_after_rdwr", 0, 1'b1, 1'b0, 32'h0000_0100, l1, 1'b0, 1'b0);
        check("perr_sticky2", {63'b0, perr[0]}, 64'h1);

        // Reset during beat 2 of a write burst
        wr[0]   = 1'b1;
        addr[0] = 32'h0000_0100;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            check("rstwr_resp", {63'b0, resp[0]}, {63'b0, (j >= 4)});
            if (j == 4) wdata[0] = 64'hAAAA_AAAA_AAAA_AAAA;
            if (j == 5) wdata[0] = 64'hBBBB_BBBB_BBBB_BBBB;
            if (j == 6) begin
                wdata[0] = 64'hCCCC_CCCC_CCCC_CCCC;
                rst = 1'b1;
            end
        end
        @(negedge clk);
        check("rstwr_resp_after", {63'b0, resp[0]}, 64'h0);
        check("rstwr_rdata_after", rdata[0], 64'h0);
        check("rstwr_perr_clr", {63'b0, perr[0]}, 64'h0);
        rst   = 1'b0;
        wr[0] = 1'b0;
        lr = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        req("rd_after_rst", 0, 1'b1, 1'b0, 32'h0000_0100, lr, 1'b0, 1'b0);

        // LATENCY=2 instance: fill 16 lines, then read them back-to-back
        for (int i = 0; i < 16; i++) begin
            sb[i] = mk_line(i);
            req("l2_wr", 1, 1'b0, 1'b1, 32'((i * 3 + 1) << 5), sb[i], 1'b0, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            req("l2_rd", 1, 1'b1, 1'b0, 32'((i * 3 + 1) << 5), sb[i], (i < 15), 1'b0);
        end
        @(negedge clk);
        check("l2_idle_resp", {63'b0, resp[1]}, 64'h0);
        check("l2_perr", {63'b0, perr[1]}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
